// File: rtl/pb_io_pkg.sv
// ============================================================================
//  Module      : pb_io_pkg
//  Description : Shared constants, interrupt FSM state type and port-decode
//                helpers for the KCPSM6 I/O and interrupt hub.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package pb_io_pkg;

    // Interrupt controller register addresses; these win over port decode
    localparam logic [7:0] IRQ_STAT_ADDR = 8'hF0;
    localparam logic [7:0] IRQ_MASK_ADDR = 8'hF1;
    localparam logic [7:0] IRQ_CLR_ADDR  = 8'hF2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        SVC  = 2'd2
    } irq_state_t;

    // General port decode: one-hot matches a single set bit, binary an index
    function automatic logic port_hit(input logic [7:0] id, input int idx,
                                      input bit onehot);
        logic [7:0] idx8;
        idx8 = idx[7:0];
        if (onehot) begin
            return (idx < 8) && (id == (8'd1 << idx8));
        end
        return id == idx8;
    endfunction

    // Constant-port decode: one-hot tests a single bit, binary the low nibble
    function automatic logic kport_hit(input logic [7:0] id, input int idx,
                                       input bit onehot);
        logic [7:0] idx8;
        idx8 = idx[7:0];
        if (onehot) begin
            return id[idx8[2:0]];
        end
        return id[3:0] == idx8[3:0];
    endfunction

endpackage

`default_nettype wire

// File: rtl/pb_irq_ctrl.sv
// ============================================================================
//  Module      : pb_irq_ctrl
//  Description : Interrupt source capture, pending/mask registers and the
//                request/acknowledge/service handshake with KCPSM6.
//                Build option PB_IO_HUB_LEVEL_IRQ_EN selects level-sensitive
//                sources instead of rising-edge capture.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pb_irq_ctrl
    import pb_io_pkg::*;
#(
    parameter int N_IRQ = 4
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic [N_IRQ-1:0] irq_req_i,
    input  logic             wr_i,
    input  logic [7:0]       addr_i,
    input  logic [N_IRQ-1:0] data_i,
    input  logic             ack_i,
    output logic [N_IRQ-1:0] pending_o,
    output logic [N_IRQ-1:0] mask_o,
    output logic             interrupt_o
);

    logic [N_IRQ-1:0] pending_q, pending_d;
    logic [N_IRQ-1:0] mask_q, mask_d;
    logic [N_IRQ-1:0] set_d, clr_d;
    irq_state_t       state_q, state_d;

`ifdef PB_IO_HUB_LEVEL_IRQ_EN
    // Level mode: an asserted source re-sets its pending bit every cycle
    always_comb set_d = irq_req_i;
`else
    logic [N_IRQ-1:0] req_prev_q;

    // Previous source sample for rising-edge detection
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) req_prev_q <= '0;
        else         req_prev_q <= irq_req_i;
    end

    // Edge mode: only a 0->1 transition sets a pending bit
    always_comb set_d = irq_req_i & ~req_prev_q;
`endif

    // Pending/mask next state and interrupt handshake FSM
    always_comb begin
        clr_d       = (wr_i && addr_i == IRQ_CLR_ADDR) ? data_i : '0;
        pending_d   = (pending_q & ~clr_d) | set_d;   // set beats clear
        mask_d      = (wr_i && addr_i == IRQ_MASK_ADDR) ? data_i : mask_q;
        state_d     = state_q;
        interrupt_o = 1'b0;
        case (state_q)
            IDLE: if (|(pending_q & mask_q)) state_d = REQ;
            REQ: begin
                interrupt_o = 1'b1;
                if (ack_i) state_d = SVC;
            end
            SVC:  if (wr_i && addr_i == IRQ_CLR_ADDR) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Interrupt controller state registers
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            pending_q <= '0;
            mask_q    <= '0;
            state_q   <= IDLE;
        end else begin
            pending_q <= pending_d;
            mask_q    <= mask_d;
            state_q   <= state_d;
        end
    end

    assign pending_o = pending_q;
    assign mask_o    = mask_q;

endmodule

`default_nettype wire

// File: rtl/pb_io_hub.sv
// ============================================================================
//  Module      : pb_io_hub
//  Description : Parametrised KCPSM6 I/O and interrupt hub: general and
//                constant output ports with write pulses, registered input
//                read mux with read-acknowledge pulses, and a maskable
//                interrupt controller. Build option PB_IO_HUB_LEVEL_IRQ_EN
//                makes interrupt sources level-sensitive.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pb_io_hub
    import pb_io_pkg::*;
#(
    parameter int N_IN   = 4,
    parameter int N_OUT  = 4,
    parameter int N_KOUT = 2,
    parameter int N_IRQ  = 4,
    parameter int ONEHOT = 1
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic [7:0]          port_id_i,
    input  logic [7:0]          out_port_i,
    input  logic                write_strobe_i,
    input  logic                k_write_strobe_i,
    input  logic                read_strobe_i,
    output logic [7:0]          in_port_o,
    output logic                interrupt_o,
    input  logic                interrupt_ack_i,
    input  logic [8*N_IN-1:0]   in_data_i,
    output logic [8*N_OUT-1:0]  out_data_o,
    output logic [N_OUT-1:0]    out_wr_o,
    output logic [8*N_KOUT-1:0] kout_data_o,
    output logic [N_IN-1:0]     in_rd_o,
    input  logic [N_IRQ-1:0]    irq_req_i
);

    localparam bit ONEHOT_B = (ONEHOT != 0);

    logic                is_ctrl;
    logic [N_OUT-1:0]    out_hit;
    logic [N_IN-1:0]     in_hit;
    logic [N_KOUT-1:0]   kout_sel;
    logic                k_found;
    logic [7:0]          rd_mux;
    logic [N_IRQ-1:0]    pending, mask;

    logic [8*N_OUT-1:0]  out_q;
    logic [N_OUT-1:0]    wr_q;
    logic [8*N_KOUT-1:0] kout_q;
    logic [7:0]          in_port_q;
    logic [N_IN-1:0]     rd_q;

    // Address decode; control addresses suppress every port hit
    always_comb begin
        is_ctrl  = port_id_i inside {IRQ_STAT_ADDR, IRQ_MASK_ADDR, IRQ_CLR_ADDR};
        out_hit  = '0;
        in_hit   = '0;
        kout_sel = '0;
        k_found  = 1'b0;
        for (int i = 0; i < N_OUT; i++) out_hit[i] = !is_ctrl && port_hit(port_id_i, i, ONEHOT_B);
        for (int i = 0; i < N_IN; i++)  in_hit[i]  = !is_ctrl && port_hit(port_id_i, i, ONEHOT_B);
        // Several one-hot bits may be set; the lowest constant port wins
        for (int j = 0; j < N_KOUT; j++) begin
            if (!k_found && !is_ctrl && kport_hit(port_id_i, j, ONEHOT_B)) begin
                kout_sel[j] = 1'b1;
                k_found     = 1'b1;
            end
        end
    end

    // Read data selection; IRQ_CLR and unmapped addresses read zero
    always_comb begin
        rd_mux = 8'h00;
        if (port_id_i == IRQ_STAT_ADDR) begin
            rd_mux[N_IRQ-1:0] = pending;
        end else if (port_id_i == IRQ_MASK_ADDR) begin
            rd_mux[N_IRQ-1:0] = mask;
        end else begin
            for (int i = 0; i < N_IN; i++) begin
                if (in_hit[i]) rd_mux = in_data_i[8*i +: 8];
            end
        end
    end

    // Output registers, write pulses, registered read data and read acks
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            out_q     <= '0;
            wr_q      <= '0;
            kout_q    <= '0;
            in_port_q <= '0;
            rd_q      <= '0;
        end else begin
            for (int i = 0; i < N_OUT; i++) begin
                if (write_strobe_i && out_hit[i]) out_q[8*i +: 8] <= out_port_i;
            end
            for (int j = 0; j < N_KOUT; j++) begin
                if (k_write_strobe_i && kout_sel[j]) kout_q[8*j +: 8] <= out_port_i;
            end
            wr_q      <= {N_OUT{write_strobe_i}} & out_hit;
            in_port_q <= rd_mux;
            rd_q      <= {N_IN{read_strobe_i}} & in_hit;
        end
    end

    pb_irq_ctrl #(
        .N_IRQ (N_IRQ)
    ) u_irq_ctrl (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .irq_req_i   (irq_req_i),
        .wr_i        (write_strobe_i),
        .addr_i      (port_id_i),
        .data_i      (out_port_i[N_IRQ-1:0]),
        .ack_i       (interrupt_ack_i),
        .pending_o   (pending),
        .mask_o      (mask),
        .interrupt_o (interrupt_o)
    );

    assign out_data_o  = out_q;
    assign out_wr_o    = wr_q;
    assign kout_data_o = kout_q;
    assign in_port_o   = in_port_q;
    assign in_rd_o     = rd_q;

endmodule

`default_nettype wire

// File: tb/tb_pb_io_hub.sv
// ============================================================================
//  Module      : tb_pb_io_hub
//  Description : Self-checking bench for pb_io_hub; a one-hot instance and a
//                binary-decode instance with eight outputs share stimulus.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_pb_io_hub;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  port_id = 8'h00;
    logic [7:0]  out_port = 8'h00;
    logic        ws = 1'b0, ks = 1'b0, rs = 1'b0, ack = 1'b0;
    logic [31:0] in_data = 32'h0;
    logic [3:0]  irq = 4'h0;

    logic [7:0]  a_in_port, b_in_port;
    logic        a_int, b_int;
    logic [31:0] a_out;
    logic [3:0]  a_wr;
    logic [63:0] b_out;
    logic [7:0]  b_wr;
    logic [15:0] a_kout, b_kout;
    logic [3:0]  a_rd, b_rd;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    pb_io_hub #(.N_IN(4), .N_OUT(4), .N_KOUT(2), .N_IRQ(4), .ONEHOT(1)) u_dut_a (
        .clk_i(clk), .rst_ni(rst_n), .port_id_i(port_id), .out_port_i(out_port),
        .write_strobe_i(ws), .k_write_strobe_i(ks), .read_strobe_i(rs),
        .in_port_o(a_in_port), .interrupt_o(a_int), .interrupt_ack_i(ack),
        .in_data_i(in_data), .out_data_o(a_out), .out_wr_o(a_wr),
        .kout_data_o(a_kout), .in_rd_o(a_rd), .irq_req_i(irq)
    );

    pb_io_hub #(.N_IN(4), .N_OUT(8), .N_KOUT(2), .N_IRQ(4), .ONEHOT(0)) u_dut_b (
        .clk_i(clk), .rst_ni(rst_n), .port_id_i(port_id), .out_port_i(out_port),
        .write_strobe_i(ws), .k_write_strobe_i(ks), .read_strobe_i(rs),
        .in_port_o(b_in_port), .interrupt_o(b_int), .interrupt_ack_i(ack),
        .in_data_i(in_data), .out_data_o(b_out), .out_wr_o(b_wr),
        .kout_data_o(b_kout), .in_rd_o(b_rd), .irq_req_i(irq)
    );

    // ---------------- behavioural model ----------------
    localparam logic [1:0] PH_QUIET = 2'd0, PH_RAISED = 2'd1, PH_SERVICED = 2'd2;

    typedef struct packed {
        logic [63:0] out;
        logic [7:0]  wr;
        logic [15:0] kout;
        logic [7:0]  inp;
        logic [3:0]  rd;
        logic [3:0]  pend;
        logic [3:0]  mask;
        logic [3:0]  prev;
        logic [1:0]  phase;
    } mdl_t;

    mdl_t ma = '0;
    mdl_t mb = '0;

    function automatic mdl_t step(input mdl_t m, input bit onehot, input int n_out);
        mdl_t       n;
        bit         ctrl;
        int         idx, kidx;
        logic [3:0] set, clr;
        n    = m;
        ctrl = (port_id == 8'hF0) || (port_id == 8'hF1) || (port_id == 8'hF2);
        // index addressed by port_id, -1 if none
        if (onehot) idx = ($countones(port_id) == 1) ? $clog2(port_id) : -1;
        else        idx = int'(port_id);
        kidx = -1;
        if (onehot) begin
            for (int b = 7; b >= 0; b--) if (port_id[b]) kidx = b;
        end else begin
            kidx = int'(port_id[3:0]);
        end
        if (ctrl) begin idx = -1; kidx = -1; end

        n.wr = '0;
        if (ws && idx >= 0 && idx < n_out) begin
            n.out[8*idx +: 8] = out_port;
            n.wr[idx] = 1'b1;
        end
        if (ks && kidx >= 0 && kidx < 2) n.kout[8*kidx +: 8] = out_port;

        if (port_id == 8'hF0)                n.inp = {4'h0, m.pend};
        else if (port_id == 8'hF1)           n.inp = {4'h0, m.mask};
        else if (idx >= 0 && idx < 4)        n.inp = in_data[8*idx +: 8];
        else                                 n.inp = 8'h00;
        n.rd = '0;
        if (rs && idx >= 0 && idx < 4) n.rd[idx] = 1'b1;

`ifdef PB_IO_HUB_LEVEL_IRQ_EN
        set = irq;
`else
        set = irq & ~m.prev;
`endif
        n.prev = irq;
        clr    = (ws && port_id == 8'hF2) ? out_port[3:0] : 4'h0;
        n.pend = (m.pend & ~clr) | set;
        if (ws && port_id == 8'hF1) n.mask = out_port[3:0];

        if (m.phase == PH_QUIET && (m.pend & m.mask) != 4'h0) n.phase = PH_RAISED;
        else if (m.phase == PH_RAISED && ack)                n.phase = PH_SERVICED;
        else if (m.phase == PH_SERVICED && ws && port_id == 8'hF2) n.phase = PH_QUIET;
        return n;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ma <= '0;
            mb <= '0;
        end else begin
            ma <= step(ma, 1'b1, 4);
            mb <= step(mb, 1'b0, 8);
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle comparison against the model
    always @(negedge clk) begin
        chk("a_out",     64'(a_out),     64'(ma.out[31:0]));
        chk("a_wr",      64'(a_wr),      64'(ma.wr[3:0]));
        chk("a_kout",    64'(a_kout),    64'(ma.kout));
        chk("a_in_port", 64'(a_in_port), 64'(ma.inp));
        chk("a_rd",      64'(a_rd),      64'(ma.rd));
        chk("a_int",     64'(a_int),     64'(ma.phase == PH_RAISED));
        chk("b_out",     b_out,          mb.out);
        chk("b_wr",      64'(b_wr),      64'(mb.wr));
        chk("b_kout",    64'(b_kout),    64'(mb.kout));
        chk("b_in_port", 64'(b_in_port), 64'(mb.inp));
        chk("b_rd",      64'(b_rd),      64'(mb.rd));
        chk("b_int",     64'(b_int),     64'(mb.phase == PH_RAISED));
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [7:0] id, input logic [7:0] d);
        port_id = id; out_port = d; ws = 1'b1;
        tick();
        ws = 1'b0;
    endtask

    task automatic kwr(input logic [7:0] id, input logic [7:0] d);
        port_id = id; out_port = d; ks = 1'b1;
        tick();
        ks = 1'b0;
    endtask

    task automatic rd(input logic [7:0] id);
        port_id = id; rs = 1'b1;
        tick();
        rs = 1'b0;
    endtask

    initial begin
        repeat (3) tick();
        chk("rst_a_out", 64'(a_out), 64'h0);
        chk("rst_b_out", b_out, 64'h0);
        chk("rst_a_int", 64'(a_int), 64'h0);
        rst_n = 1'b1;
        tick();

        // one-hot general write
        wr(8'h04, 8'hA5);
        chk("oh_wr_byte2", 64'(a_out[23:16]), 64'hA5);
        chk("oh_wr_pulse", 64'(a_wr), 64'h4);
        chk("oh_wr_others", 64'({a_out[31:24], a_out[15:0]}), 64'h0);
        tick();
        chk("oh_wr_pulse_end", 64'(a_wr), 64'h0);

        // binary general write, then an unmapped address
        wr(8'h07, 8'h3C);
        chk("bin_port7", 64'(b_out[63:56]), 64'h3C);
        chk("bin_wr_pulse", 64'(b_wr), 64'h80);
        wr(8'h09, 8'h55);
        chk("bin_unmapped_data", b_out, 64'h3C0000A5_00000000);
        chk("bin_unmapped_pulse", 64'(b_wr), 64'h0);

        // constant ports: lowest one-hot bit wins; binary uses the low nibble
        kwr(8'h03, 8'h77);
        chk("oh_kout_lowest", 64'(a_kout), 64'h0077);
        chk("bin_kout_none", 64'(b_kout), 64'h0);
        kwr(8'h11, 8'h99);
        chk("oh_kout_bit0", 64'(a_kout), 64'h0099);
        chk("bin_kout_port1", 64'(b_kout), 64'h9900);

        // read path
        in_data = 32'h33_22_5A_11;
        rd(8'h02);
        chk("oh_read_p1", 64'(a_in_port), 64'h5A);
        chk("oh_rd_pulse", 64'(a_rd), 64'h2);
        chk("bin_read_p2", 64'(b_in_port), 64'h22);
        chk("bin_rd_pulse", 64'(b_rd), 64'h4);
        tick();
        chk("oh_rd_pulse_end", 64'(a_rd), 64'h0);
        port_id = 8'h20;
        tick();
        chk("oh_read_unmapped", 64'(a_in_port), 64'h00);

        // masked interrupt request, ack, status, clear
        wr(8'hF1, 8'h05);
        irq = 4'b0100;
        tick();
        irq = 4'b0000;
        tick();
        tick();
        chk("irq_raised", 64'(a_int), 64'h1);
        port_id = 8'hF0;
        tick();
        chk("irq_stat", 64'(a_in_port), 64'h04);
        ack = 1'b1;
        tick();
        ack = 1'b0;
        chk("irq_ack_low", 64'(a_int), 64'h0);
        wr(8'hF2, 8'h04);
        chk("irq_clr_low", 64'(a_int), 64'h0);
        tick();
        chk("irq_idle_low", 64'(a_int), 64'h0);

        // new source during service re-raises one cycle after the clear
        irq = 4'b0100;
        tick();
        irq = 4'b0000;
        tick();
        tick();
        ack = 1'b1;
        tick();
        ack = 1'b0;
        irq = 4'b0001;
        tick();
        irq = 4'b0000;
        tick();
        wr(8'hF2, 8'h04);
        chk("reraise_clr_edge", 64'(a_int), 64'h0);
        tick();
        chk("reraise_next", 64'(a_int), 64'h1);
        ack = 1'b1;
        tick();
        ack = 1'b0;
        wr(8'hF2, 8'h01);
        tick();

        // set beats clear in the same cycle
        port_id = 8'hF2; out_port = 8'h02; ws = 1'b1; irq = 4'b0010;
        tick();
        ws = 1'b0; irq = 4'b0000;
        port_id = 8'hF0;
        tick();
        chk("set_wins", 64'(a_in_port), 64'h02);
        chk("set_wins_no_irq", 64'(a_int), 64'h0);

        // reset while requesting
        wr(8'hF1, 8'h07);
        tick();
        chk("req_before_rst", 64'(a_int), 64'h1);
        rst_n = 1'b0;
        #1;
        chk("rst_mid_int", 64'(a_int), 64'h0);
        tick();
        rst_n = 1'b1;
        port_id = 8'hF0;
        tick();
        chk("rst_mid_pending", 64'(a_in_port), 64'h00);

        repeat (3) tick();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
